lcd_frame_writer: RTL and testbench

Receives the PPU's pixel stream and writes each pixel into a double-buffered 2-bit-per-pixel framebuffer, at the address given by scanline and column. It tracks line and frame boundaries from the PPU's HBlank/VBlank strobes and resynchronises on protocol violations. When a frame completes, it flips buffers so the video-out scanner always reads a complete frame. It sits between `PixelProcessingUnit` and the framebuffer BRAM write port.

---
 rtl/ppu_pkg.sv | 18 +
 rtl/lcd_frame_writer.sv | 136 +++++++++++++
 tb/tb_lcd_frame_writer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: framebuffer geometry, pixel type and the
// frame-writer state encoding.
package ppu_pkg;

   localparam int H_PIXELS      = 160;
   localparam int V_LINES       = 144;
   localparam int FB_BANK_DEPTH = 23040;

   typedef logic [1:0] pixel_t;

   typedef enum logic [1:0] {
      WaitSync = 2'd0,
      Active   = 2'd1,
      LineEnd  = 2'd2,
      FrameEnd = 2'd3
   } LcdWriterState;

endpackage

// File: rtl/lcd_frame_writer.sv
// Writes the PPU pixel stream into a double-buffered framebuffer, tracking
// line/frame boundaries from the blanking strobes and flipping banks per frame.
//
// state    | meaning
// WaitSync | after reset, ignore everything until the first vblank
// Active   | accepting pixels of the current line
// LineEnd  | line full, waiting for hblank
// FrameEnd | last line done, waiting for vblank to flip banks
module lcd_frame_writer #(
   parameter int H_PIXELS = ppu_pkg::H_PIXELS,
   parameter int V_LINES  = ppu_pkg::V_LINES,
   parameter int PIXEL_W  = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               pixel_valid_in,
   input  logic [PIXEL_W-1:0] pixel_in,
   input  logic               hblank_in,
   input  logic               vblank_in,
   output logic               fb_we_out,
   output logic [15:0]        fb_addr_out,
   output logic [PIXEL_W-1:0] fb_data_out,
   output logic               disp_bank_out,
   output logic               frame_done_out,
   output logic               sync_err_out
);
   import ppu_pkg::*;

   localparam logic [7:0]  X_LAST   = 8'(H_PIXELS - 1);
   localparam logic [7:0]  Y_LAST   = 8'(V_LINES - 1);
   localparam logic [14:0] ROW_STEP = 15'(H_PIXELS);
   localparam logic [15:0] BANK_OFF = 16'(H_PIXELS * V_LINES);

   LcdWriterState state, state_n, state_mid;
   logic [7:0]    x, x_n, x_mid;
   logic [7:0]    y, y_n;
   logic [14:0]   row, row_n;
   logic          bank, bank_n;
   logic          err_n;
   logic          we_n;
   logic [15:0]   addr_n;
   logic [PIXEL_W-1:0] data_n;
   logic          done_n;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= WaitSync;
         x              <= '0;
         y              <= '0;
         row            <= '0;
         bank           <= 1'b0;
         sync_err_out   <= 1'b0;
         fb_we_out      <= 1'b0;
         fb_addr_out    <= '0;
         fb_data_out    <= '0;
         frame_done_out <= 1'b0;
      end else begin
         state          <= state_n;
         x              <= x_n;
         y              <= y_n;
         row            <= row_n;
         bank           <= bank_n;
         sync_err_out   <= err_n;
         fb_we_out      <= we_n;
         fb_addr_out    <= addr_n;
         fb_data_out    <= data_n;
         frame_done_out <= done_n;
      end
   end

   always_comb begin
      state_mid = state;
      x_mid     = x;
      state_n   = state;
      x_n       = x;
      y_n       = y;
      row_n     = row;
      bank_n    = bank;
      err_n     = sync_err_out;
      we_n      = 1'b0;
      addr_n    = fb_addr_out;
      data_n    = fb_data_out;
      done_n    = 1'b0;

      // Pixel first; any strobe this cycle is judged against the post-pixel state.
      if (pixel_valid_in) begin
         case (state)
            Active: begin
               we_n   = 1'b1;
               addr_n = (bank ? BANK_OFF : 16'd0) + 16'(row) + 16'(x);
               data_n = pixel_in;
               if (x == X_LAST) begin
                  x_mid     = '0;
                  state_mid = LineEnd;
               end else begin
                  x_mid = x + 8'd1;
               end
            end
            LineEnd, FrameEnd: err_n = 1'b1;
            default: ;
         endcase
      end

      state_n = state_mid;
      x_n     = x_mid;

      if (vblank_in) begin
         case (state_mid)
            Active, LineEnd: err_n = 1'b1;
            FrameEnd: begin
               bank_n = ~bank;
               done_n = 1'b1;
            end
            default: ;
         endcase
         state_n = Active;
         x_n     = '0;
         y_n     = '0;
         row_n   = '0;
      end else if (hblank_in && (state_mid == Active || state_mid == LineEnd)) begin
         if (state_mid == Active)
            err_n = 1'b1;
         x_n = '0;
         if (y == Y_LAST) begin
            state_n = FrameEnd;
         end else begin
            y_n     = y + 8'd1;
            row_n   = row + ROW_STEP;
            state_n = Active;
         end
      end
   end

   assign disp_bank_out = ~bank;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer: full frames, bank flips, and each
// protocol-violation recovery path.
module tb_lcd_frame_writer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        pixel_valid_in = 1'b0;
   logic [1:0]  pixel_in = '0;
   logic        hblank_in = 1'b0;
   logic        vblank_in = 1'b0;
   logic        fb_we_out;
   logic [15:0] fb_addr_out;
   logic [1:0]  fb_data_out;
   logic        disp_bank_out;
   logic        frame_done_out;
   logic        sync_err_out;

   int n_checks = 0;
   int n_errors = 0;

   lcd_frame_writer dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .pixel_valid_in (pixel_valid_in),
      .pixel_in       (pixel_in),
      .hblank_in      (hblank_in),
      .vblank_in      (vblank_in),
      .fb_we_out      (fb_we_out),
      .fb_addr_out    (fb_addr_out),
      .fb_data_out    (fb_data_out),
      .disp_bank_out  (disp_bank_out),
      .frame_done_out (frame_done_out),
      .sync_err_out   (sync_err_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One clock with the given inputs; returns #1 after the edge so the
   // registered outputs reflect this cycle.
   task automatic step(input logic v, input logic [1:0] p, input logic hb, input logic vb);
      pixel_valid_in = v;
      pixel_in       = p;
      hblank_in      = hb;
      vblank_in      = vb;
      @(posedge clk_in);
      #1;
      pixel_valid_in = 1'b0;
      hblank_in      = 1'b0;
      vblank_in      = 1'b0;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
   endtask

   function automatic logic [1:0] pat(input int x, input int y);
      return 2'(x + 3 * y);
   endfunction

   task automatic run_pixels(input string tag, input int base, input int y, input int x0, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         int x;
         logic [1:0] p;
         x = x0 + i;
         p = pat(x, y);
         step(1'b1, p, 1'b0, 1'b0);
         if (fb_we_out !== 1'b1 || fb_addr_out !== 16'(base + y * 160 + x) || fb_data_out !== p)
            bad++;
         if (frame_done_out !== 1'b0)
            bad++;
      end
      chk(tag, bad, 0);
   endtask

   task automatic run_lines(input string tag, input int base, input int n_lines);
      for (int y = 0; y < n_lines; y++) begin
         run_pixels(tag, base, y, 0, 160);
         step(1'b0, 2'd0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      do_reset();
      rst_in = 1'b1;
      #1;
      chk("rst_we", fb_we_out, 0);
      chk("rst_addr", fb_addr_out, 0);
      chk("rst_data", fb_data_out, 0);
      chk("rst_disp_bank", disp_bank_out, 1);
      chk("rst_done", frame_done_out, 0);
      chk("rst_err", sync_err_out, 0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;

      // Pixels and hblank before any vblank are ignored silently
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'd3, (i == 1) ? 1'b1 : 1'b0, 1'b0);
         chk("presync_we", fb_we_out, 0);
      end
      chk("presync_err", sync_err_out, 0);

      // Last pixel together with hblank is a legal line end
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("sync_err", sync_err_out, 0);
      chk("sync_done", frame_done_out, 0);
      run_pixels("same_line0", 0, 0, 0, 159);
      step(1'b1, 2'd2, 1'b1, 1'b0);
      chk("same_we", fb_we_out, 1);
      chk("same_addr", fb_addr_out, 159);
      chk("same_data", fb_data_out, 2);
      step(1'b1, 2'd1, 1'b0, 1'b0);
      chk("same_next_addr", fb_addr_out, 160);
      chk("same_next_data", fb_data_out, 1);
      chk("same_err", sync_err_out, 0);

      // Asynchronous reset right after a write cancels it immediately
      step(1'b1, 2'd3, 1'b0, 1'b0);
      chk("pre_rst_we", fb_we_out, 1);
      rst_in = 1'b1;
      #1;
      chk("async_rst_we", fb_we_out, 0);
      chk("async_rst_addr", fb_addr_out, 0);
      chk("async_rst_data", fb_data_out, 0);
      #1;
      rst_in = 1'b0;

      // Extra pixel after x=159 is dropped and flagged
      step(1'b0, 2'd0, 1'b0, 1'b1);
      run_pixels("extra_line0", 0, 0, 0, 160);
      chk("extra_pre_err", sync_err_out, 0);
      step(1'b1, 2'd1, 1'b0, 1'b0);
      chk("extra_we", fb_we_out, 0);
      chk("extra_err", sync_err_out, 1);
      step(1'b0, 2'd0, 1'b1, 1'b0);
      step(1'b1, 2'd2, 1'b0, 1'b0);
      chk("extra_next_we", fb_we_out, 1);
      chk("extra_next_addr", fb_addr_out, 160);

      // Short line of 100 pixels
      do_reset();
      step(1'b0, 2'd0, 1'b0, 1'b1);
      run_pixels("short_line0", 0, 0, 0, 100);
      step(1'b0, 2'd0, 1'b1, 1'b0);
      chk("short_err", sync_err_out, 1);
      step(1'b1, 2'd3, 1'b0, 1'b0);
      chk("short_next_we", fb_we_out, 1);
      chk("short_next_addr", fb_addr_out, 160);
      chk("short_next_data", fb_data_out, 3);

      // Full frame into bank 0
      do_reset();
      step(1'b0, 2'd0, 1'b0, 1'b1);
      run_lines("frame0", 0, 144);
      chk("frame0_disp_before", disp_bank_out, 1);
      step(1'b1, 2'd1, 1'b1, 1'b0);
      chk("frame_end_pixel_we", fb_we_out, 0);
      chk("frame_end_pixel_err", sync_err_out, 1);
      do_reset();
      step(1'b0, 2'd0, 1'b0, 1'b1);
      run_lines("frame0b", 0, 144);
      step(1'b0, 2'd0, 1'b1, 1'b0);
      chk("frame0_hb_in_fe_err", sync_err_out, 0);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("frame0_done", frame_done_out, 1);
      chk("frame0_disp", disp_bank_out, 0);
      chk("frame0_err", sync_err_out, 0);
      step(1'b0, 2'd0, 1'b0, 1'b0);
      chk("frame0_done_pulse", frame_done_out, 0);

      // Frame truncated at y=50 in bank 1
      run_lines("trunc", 23040, 50);
      run_pixels("trunc_y50", 23040, 50, 0, 10);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("trunc_err", sync_err_out, 1);
      chk("trunc_disp", disp_bank_out, 0);
      chk("trunc_done", frame_done_out, 0);
      step(1'b1, 2'd2, 1'b0, 1'b0);
      chk("trunc_next_addr", fb_addr_out, 23040);
      chk("trunc_next_we", fb_we_out, 1);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("trunc2_done", frame_done_out, 0);

      // Full frame into bank 1 (addresses 23040..46079), then flip back
      run_lines("frame1", 23040, 144);
      chk("frame1_last_addr", fb_addr_out, 46079);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("frame1_done", frame_done_out, 1);
      chk("frame1_disp", disp_bank_out, 1);
      step(1'b1, 2'd0, 1'b0, 1'b0);
      chk("frame2_first_addr", fb_addr_out, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
